// File: rtl/axis_seq_frame_checker_pkg.sv
// Shared types and constants for the AXI-Stream sequence/frame checker.
package axis_seq_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } chk_state_e;

  localparam int unsigned LEN_W               = 16;
  localparam int unsigned LFSR_W              = 7;
  localparam logic [LFSR_W-1:0] LFSR_SEED     = 7'h01;

  // Beat counter increment that sticks at all-ones
  function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] v);
    return (v == {LEN_W{1'b1}}) ? v : v + LEN_W'(1);
  endfunction

endpackage

// File: rtl/axis_seq_frame_checker_if.sv
// AXI-Stream bundle carried between the pattern source and the checker.
interface axi_stream_inf #(
  parameter int unsigned DSIZE = 16,
  parameter int unsigned USIZE = 1
);
  logic             axis_tvalid;
  logic             axis_tready;
  logic [DSIZE-1:0] axis_tdata;
  logic             axis_tlast;
  logic [USIZE-1:0] axis_tuser;

  modport master (
    output axis_tvalid, axis_tdata, axis_tlast, axis_tuser,
    input  axis_tready
  );

  modport slave (
    input  axis_tvalid, axis_tdata, axis_tlast, axis_tuser,
    output axis_tready
  );
endinterface

// File: rtl/axis_seq_frame_checker_lfsr.sv
// Pseudo-random tready gate (x^7+x^6+1); only built with AXIS_SEQ_CHK_THROTTLE_EN,
// so the default build carries no throttle logic at all.
`ifdef AXIS_SEQ_CHK_THROTTLE_EN
module axis_tready_lfsr
  import axis_seq_chk_pkg::*;
(
  input  logic clock,
  input  logic rst,
  output logic en_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              en_q;

  // Fibonacci shift; en low when the two LSBs are both zero (~25% of states)
  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[6] ^ lfsr_q[5]};
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
      en_q   <= (LFSR_SEED[1:0] != 2'b00);
    end else begin
      lfsr_q <= lfsr_d;
      en_q   <= (lfsr_d[1:0] != 2'b00);
    end
  end

  assign en_o = en_q;

endmodule
`endif

// File: rtl/axis_seq_frame_checker.sv
// Stream sink checking each frame for an incrementing data sequence and legal length.
// Define AXIS_SEQ_CHK_THROTTLE_EN to add LFSR-driven backpressure on tready.
module axis_seq_frame_checker
  import axis_seq_chk_pkg::*;
#(
  parameter int unsigned DSIZE   = 16,
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                clock,
  input  logic                rst,
  axi_stream_inf.slave        origin_inf,
  input  logic                clr,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [LEN_W-1:0]    last_len,
  output logic                err_flag
);

  chk_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DSIZE-1:0]  exp_q, exp_d;
  logic              ferr_q, ferr_d;
  logic              rdy_q;
  logic              done_c;
  logic              tready;
  logic              acc;

  logic [CNT_W-1:0]  frame_cnt_q, err_cnt_q;
  logic [LEN_W-1:0]  last_len_q;
  logic              err_flag_q;

  logic              unused_tuser;
  assign unused_tuser = ^origin_inf.axis_tuser;

`ifdef AXIS_SEQ_CHK_THROTTLE_EN
  logic lfsr_en;

  axis_tready_lfsr u_tready_lfsr (
    .clock (clock),
    .rst   (rst),
    .en_o  (lfsr_en)
  );

  assign tready = rdy_q & lfsr_en;
`else
  assign tready = rdy_q;
`endif

  assign origin_inf.axis_tready = tready;
  assign acc = origin_inf.axis_tvalid & tready;

  // Frame FSM: sequence compare, length tracking, completion strobe
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    exp_d   = exp_q;
    ferr_d  = ferr_q;
    done_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (acc) begin
          exp_d  = origin_inf.axis_tdata + DSIZE'(1);
          len_d  = LEN_W'(1);
          ferr_d = 1'b0;
          if (origin_inf.axis_tlast) begin
            done_c = 1'b1;
          end else if (MAX_LEN <= 1) begin
            ferr_d  = 1'b1;
            state_d = DROP;
          end else begin
            state_d = BODY;
          end
        end
      end

      BODY: begin
        if (acc) begin
          if (origin_inf.axis_tdata != exp_q) ferr_d = 1'b1;
          exp_d = origin_inf.axis_tdata + DSIZE'(1);
          len_d = len_sat_inc(len_q);
          if (origin_inf.axis_tlast) begin
            done_c  = 1'b1;
            state_d = IDLE;
          end else if (len_d == LEN_W'(MAX_LEN)) begin
            ferr_d  = 1'b1;
            state_d = DROP;
          end
        end
      end

      DROP: begin
        if (acc) begin
          len_d  = len_sat_inc(len_q);
          ferr_d = 1'b1;
          if (origin_inf.axis_tlast) begin
            done_c  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, length, expected-data registers; tready comes up one cycle after reset
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      exp_q   <= '0;
      ferr_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      exp_q   <= exp_d;
      ferr_q  <= ferr_d;
      rdy_q   <= 1'b1;
    end
  end

  // Statistics: clr beats a simultaneous completion, but last_len still records it
  always_ff @(posedge clock) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      last_len_q  <= '0;
      err_flag_q  <= 1'b0;
    end else begin
      if (done_c) last_len_q <= len_d;
      if (clr) begin
        frame_cnt_q <= '0;
        err_cnt_q   <= '0;
        err_flag_q  <= 1'b0;
      end else if (done_c) begin
        if (frame_cnt_q != {CNT_W{1'b1}}) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        if (ferr_d) begin
          if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + CNT_W'(1);
          err_flag_q <= 1'b1;
        end
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign last_len  = last_len_q;
  assign err_flag  = err_flag_q;

endmodule

// File: tb/tb_axis_seq_frame_checker.sv
// Scoreboard bench for axis_seq_frame_checker (MAX_LEN=16); runs in either throttle build.
module tb_axis_seq_frame_checker;

  localparam int unsigned DSIZE   = 16;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned CNT_W   = 32;

  typedef struct {
    logic [15:0] len;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic [CNT_W-1:0] frame_cnt, err_cnt;
  logic [15:0]      last_len;
  logic             err_flag;

  axi_stream_inf #(.DSIZE(DSIZE), .USIZE(1)) inf ();

  axis_seq_frame_checker #(.DSIZE(DSIZE), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clock      (clk),
    .rst        (rst),
    .origin_inf (inf.slave),
    .clr        (clr),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt),
    .last_len   (last_len),
    .err_flag   (err_flag)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  int   gap_pct = 0;
  bit   cnt_en = 1'b0;
  int   cyc_tot = 0;
  int   cyc_low = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Offer one beat and hold it until accepted; called at posedge+1
  task automatic drive_beat(input logic [15:0] d, input bit last, input bit clr_v);
    bit ok = 1'b0;
    inf.axis_tvalid = 1'b1;
    inf.axis_tdata  = d;
    inf.axis_tlast  = last;
    clr             = clr_v;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      ok = (inf.axis_tready === 1'b1);
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) chk("tready_timeout", 32'd0, 32'd1);
    clr = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] start, input int n, input int bad, input bit clr_last);
    exp_t e;
    logic [15:0] d;
    e.len = 16'(n);
    e.err = (bad > 0 && bad < n) || (n > int'(MAX_LEN));
    sb_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        inf.axis_tvalid = 1'b0;
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
      d = start + 16'(i) + ((bad > 0 && i >= bad) ? 16'd1 : 16'd0);
      drive_beat(d, (i == n - 1), clr_last && (i == n - 1));
    end
    inf.axis_tvalid = 1'b0;
    inf.axis_tlast  = 1'b0;
  endtask

  // Monitor: replay the previous edge into the model, compare on each completion
  initial begin
    exp_t        e;
    bit          p_rst = 1'b0, p_clr = 1'b0, p_done = 1'b0;
    logic [31:0] m_frame = '0, m_err = '0;
    logic [15:0] m_len = '0;
    bit          m_flag = 1'b0;
    forever begin
      @(negedge clk);
      if (p_rst) begin
        m_frame = '0; m_err = '0; m_len = '0; m_flag = 1'b0;
      end else begin
        if (p_done) begin
          if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            m_len = e.len;
            if (!p_clr) begin
              if (m_frame != '1) m_frame++;
              if (e.err) begin
                if (m_err != '1) m_err++;
                m_flag = 1'b1;
              end
            end
          end
        end
        if (p_clr) begin
          m_frame = '0; m_err = '0; m_flag = 1'b0;
        end
        if (p_done) begin
          chk("sb_last_len",  32'(last_len), 32'(m_len));
          chk("sb_frame_cnt", frame_cnt, m_frame);
          chk("sb_err_cnt",   err_cnt, m_err);
          chk("sb_err_flag",  32'(err_flag), 32'(m_flag));
        end
      end
      if (cnt_en) begin
        cyc_tot++;
        if (inf.axis_tready !== 1'b1) cyc_low++;
      end
      p_rst  = (rst === 1'b1);
      p_clr  = (clr === 1'b1);
      p_done = (rst === 1'b0) && (inf.axis_tvalid === 1'b1) &&
               (inf.axis_tready === 1'b1) && (inf.axis_tlast === 1'b1);
    end
  end

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    inf.axis_tvalid = 1'b0;
    inf.axis_tdata  = '0;
    inf.axis_tlast  = 1'b0;
    inf.axis_tuser  = '0;

    // Reset values and tready release timing
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_frame_cnt", frame_cnt, 32'd0);
    chk("rst_err_cnt",   err_cnt, 32'd0);
    chk("rst_last_len",  32'(last_len), 32'd0);
    chk("rst_err_flag",  32'(err_flag), 32'd0);
    chk("rst_tready",    32'(inf.axis_tready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", 32'(inf.axis_tready), 32'd0);
    @(posedge clk); #1;
    chk("tready_up", 32'(inf.axis_tready), 32'd1);

    // Four clean 8-beat frames, continuous tvalid
    for (int f = 0; f < 4; f++) send_frame(16'd0, 8, 0, 1'b0);
    chk("t1_frame_cnt", frame_cnt, 32'd4);
    chk("t1_err_cnt",   err_cnt, 32'd0);
    chk("t1_last_len",  32'(last_len), 32'd8);
    chk("t1_err_flag",  32'(err_flag), 32'd0);

    // Sequence break 10,11,13,14 then a good frame
    send_frame(16'd10, 4, 2, 1'b0);
    chk("t2_err_cnt",  err_cnt, 32'd1);
    chk("t2_err_flag", 32'(err_flag), 32'd1);
    chk("t2_last_len", 32'(last_len), 32'd4);
    send_frame(16'd100, 6, 0, 1'b0);
    chk("t2_err_hold", err_cnt, 32'd1);

    // Data wrap and single-beat frame
    send_frame(16'hFFFE, 4, 0, 1'b0);
    chk("t3_wrap_err", err_cnt, 32'd1);
    send_frame(16'h1234, 1, 0, 1'b0);
    chk("t3_single_len", 32'(last_len), 32'd1);
    chk("t3_frame_cnt",  frame_cnt, 32'd8);

    // Length limit: exactly MAX_LEN, one over, 21 beats, then clean
    send_frame(16'd0, 16, 0, 1'b0);
    chk("t4_max_ok", err_cnt, 32'd1);
    send_frame(16'd0, 17, 0, 1'b0);
    chk("t4_over_err", err_cnt, 32'd2);
    send_frame(16'd0, 21, 0, 1'b0);
    chk("t4_len21", 32'(last_len), 32'd21);
    send_frame(16'd50, 4, 0, 1'b0);
    chk("t4_after_err", err_cnt, 32'd3);

    // Reset on beat 3 of 6 drops the partial frame
    drive_beat(16'd0, 1'b0, 1'b0);
    drive_beat(16'd1, 1'b0, 1'b0);
    inf.axis_tdata = 16'd2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    inf.axis_tvalid = 1'b0;
    rst = 1'b0;
    send_frame(16'd7, 5, 0, 1'b0);
    chk("t5_frame_cnt", frame_cnt, 32'd1);
    chk("t5_err_cnt",   err_cnt, 32'd0);
    send_frame(16'd3, 5, 0, 1'b1);
    chk("t5_clr_frame", frame_cnt, 32'd0);
    chk("t5_clr_len",   32'(last_len), 32'd5);

    // Random clean frames with random tvalid gaps
    gap_pct = 30;
    cnt_en  = 1'b1;
    for (int f = 0; f < 300; f++)
      send_frame(16'($urandom), int'($urandom_range(MAX_LEN, 1)), 0, 1'b0);
    cnt_en = 1'b0;
    chk("rnd_err_cnt", err_cnt, 32'd0);
    chk("rnd_frame_cnt", frame_cnt, 32'd300);
`ifdef AXIS_SEQ_CHK_THROTTLE_EN
    chk("rnd_tready_low_pct", 32'((cyc_low * 100 >= cyc_tot * 15) && (cyc_low * 100 <= cyc_tot * 35)), 32'd1);
`else
    chk("rnd_tready_low", 32'(cyc_low), 32'd0);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
